// File: rtl/blk_mask_streamer.sv
// Block-mask to decimated-tile streamer: buffers whole block-rows of match masks in a
// NUM_BUFS-deep ring and emits raster-order DEC x DEC popcount tiles with ready/valid.
module blk_mask_streamer #(
  parameter  int BLK_W    = 16,
  parameter  int BLK_H    = 16,
  parameter  int FRAME_W  = 240,
  parameter  int DEC      = 2,
  parameter  int NUM_BUFS = 2,
  parameter  int DISP_W   = 5,
  parameter  int CONF_W   = 8,
  localparam int CNT_W    = $clog2(DEC*DEC+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BLK_W*BLK_H-1:0] xors_in,
  input  logic [CONF_W-1:0]      conf_in,
  input  logic [DISP_W-1:0]      disp_in,
  input  logic                   xors_valid,
  output logic                   xors_ready,
  output logic [CNT_W-1:0]       out_count,
  output logic [CONF_W-1:0]      out_conf,
  output logic [DISP_W-1:0]      out_disp,
  output logic                   out_sol,
  output logic                   out_eol,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int BPR        = FRAME_W / BLK_W;
  localparam int TPR        = FRAME_W / DEC;
  localparam int TROWS      = BLK_H / DEC;
  localparam int TPB        = BLK_W / DEC;
  localparam int BLK_BITS   = BLK_W * BLK_H;
  localparam int MEM_ROWS   = NUM_BUFS * BPR * BLK_H;
  localparam int SIDE_DEPTH = NUM_BUFS * BPR;
  localparam int AW         = $clog2(MEM_ROWS);
  localparam int SAW        = (SIDE_DEPTH > 1) ? $clog2(SIDE_DEPTH) : 1;
  localparam int BUF_W      = $clog2(NUM_BUFS);
  localparam int BCOL_W     = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int ROW_W      = (BLK_H > 1) ? $clog2(BLK_H) : 1;
  localparam int COL_W      = (BLK_W > 1) ? $clog2(BLK_W) : 1;
  localparam int BB_W       = $clog2(BLK_BITS);
  localparam int TX_W       = (TPR > 1) ? $clog2(TPR) : 1;
  localparam int TY_W       = (TROWS > 1) ? $clog2(TROWS) : 1;
  localparam int FILL_W     = $clog2(NUM_BUFS + 1);
  localparam int STEP_W     = $clog2(DEC + 1);

  typedef enum logic       {W_IDLE, W_ROWS}          w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_HOLD} r_state_t;

  function automatic logic [CNT_W-1:0] popcnt(input logic [DEC-1:0] v);
    logic [CNT_W-1:0] pc;
    pc = '0;
    for (int i = 0; i < DEC; i++) pc = pc + CNT_W'(v[i]);
    return pc;
  endfunction

  // ---------------- write side ----------------
  w_state_t             w_state, w_next;
  logic [BLK_BITS-1:0]  mask_q;
  logic [ROW_W-1:0]     wr_row;
  logic [BCOL_W-1:0]    wr_col;
  logic [BUF_W-1:0]     wr_buf;
  logic [FILL_W-1:0]    fill;
  logic                 accept, wr_last_row, commit;
  logic [AW-1:0]        wr_addr;
  logic [SAW-1:0]       side_wr_addr;
  logic [BB_W-1:0]      wr_bit;

  assign xors_ready   = (w_state == W_IDLE) && (fill < FILL_W'(NUM_BUFS));
  assign accept       = xors_valid && xors_ready;
  assign wr_last_row  = (wr_row == ROW_W'(BLK_H - 1));
  assign commit       = (w_state == W_ROWS) && wr_last_row && (wr_col == BCOL_W'(BPR - 1));
  assign wr_addr      = AW'((int'(wr_buf) * BPR + int'(wr_col)) * BLK_H + int'(wr_row));
  assign side_wr_addr = SAW'(int'(wr_buf) * BPR + int'(wr_col));
  assign wr_bit       = BB_W'(int'(wr_row) * BLK_W);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (accept) w_next = W_ROWS;
      W_ROWS:  if (wr_last_row) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q <= '0;
      wr_row <= '0;
      wr_col <= '0;
      wr_buf <= '0;
    end else if (accept) begin
      mask_q <= xors_in;
      wr_row <= '0;
    end else if (w_state == W_ROWS) begin
      wr_row <= wr_row + ROW_W'(1);
      if (wr_last_row) begin
        if (wr_col == BCOL_W'(BPR - 1)) begin
          wr_col <= '0;
          wr_buf <= wr_buf + BUF_W'(1);
        end else begin
          wr_col <= wr_col + BCOL_W'(1);
        end
      end
    end
  end

  // ---------------- read side ----------------
  r_state_t             r_state, r_next;
  logic [STEP_W-1:0]    step;
  logic [TX_W-1:0]      tx;
  logic [TY_W-1:0]      ty;
  logic [BUF_W-1:0]     rd_buf;
  logic [CNT_W-1:0]     acc, tile_pc;
  logic                 rd_issue, side_issue, tile_last_x, tile_last, release_buf;
  logic [AW-1:0]        rd_addr;
  logic [SAW-1:0]       side_rd_addr;
  logic [COL_W-1:0]     rd_col;
  logic [BLK_W-1:0]     rd_row_q;
  logic [CONF_W+DISP_W-1:0] side_q;

  assign rd_issue     = (r_state == R_FETCH) && (step < STEP_W'(DEC));
  assign side_issue   = (r_state == R_FETCH) && (step == '0);
  assign tile_last_x  = (tx == TX_W'(TPR - 1));
  assign tile_last    = tile_last_x && (ty == TY_W'(TROWS - 1));
  assign release_buf  = (r_state == R_HOLD) && out_ready && tile_last;
  assign rd_addr      = AW'((int'(rd_buf) * BPR + int'(tx) / TPB) * BLK_H
                            + int'(ty) * DEC + int'(step));
  assign side_rd_addr = SAW'(int'(rd_buf) * BPR + int'(tx) / TPB);
  assign rd_col       = COL_W'((int'(tx) % TPB) * DEC);
  assign tile_pc      = popcnt(rd_row_q[rd_col +: DEC]);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (fill != '0) r_next = R_FETCH;
      R_FETCH: if (step == STEP_W'(DEC)) r_next = R_HOLD;
      R_HOLD:  if (out_ready) r_next = tile_last ? R_IDLE : R_FETCH;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  // Fetch step s issues row s; its data is accumulated one step later, the last at step DEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step      <= '0;
      acc       <= '0;
      tx        <= '0;
      ty        <= '0;
      rd_buf    <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_conf  <= '0;
      out_disp  <= '0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          step <= '0;
          acc  <= '0;
        end
        R_FETCH: begin
          step <= step + STEP_W'(1);
          if (step != '0) acc <= acc + tile_pc;
          if (step == STEP_W'(DEC)) begin
            out_valid <= 1'b1;
            out_count <= acc + tile_pc;
            out_conf  <= side_q[CONF_W+DISP_W-1:DISP_W];
            out_disp  <= side_q[DISP_W-1:0];
            out_sol   <= (tx == '0);
            out_eol   <= tile_last_x;
          end
        end
        R_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            step      <= '0;
            acc       <= '0;
            if (tile_last_x) begin
              tx <= '0;
              if (tile_last) begin
                ty     <= '0;
                rd_buf <= rd_buf + BUF_W'(1);
              end else begin
                ty <= ty + TY_W'(1);
              end
            end else begin
              tx <= tx + TX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill <= '0;
    end else if (commit && !release_buf) begin
      fill <= fill + FILL_W'(1);
    end else if (!commit && release_buf) begin
      fill <= fill - FILL_W'(1);
    end
  end

  // ---------------- storage ----------------
  logic [BLK_W-1:0]         mask_mem [MEM_ROWS];
  logic [CONF_W+DISP_W-1:0] side_mem [SIDE_DEPTH];

  // NOTE: the RAMs and their read registers are not reset; fill=0 guarantees stale contents are never read.
  always_ff @(posedge clk) begin
    if (w_state == W_ROWS) mask_mem[wr_addr] <= mask_q[wr_bit +: BLK_W];
    if (accept)            side_mem[side_wr_addr] <= {conf_in, disp_in};
    if (rd_issue)          rd_row_q <= mask_mem[rd_addr];
    if (side_issue)        side_q <= side_mem[side_rd_addr];
  end

endmodule

// File: tb/tb_blk_mask_streamer.sv
// Directed bench for blk_mask_streamer at default parameters: a tile model fed from the
// block-row arrays predicts every output tile; hand-computed spot values back it up.
module tb_blk_mask_streamer;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] xors_in;
  logic [7:0]   conf_in;
  logic [4:0]   disp_in;
  logic         xors_valid;
  logic         xors_ready;
  logic [2:0]   out_count;
  logic [7:0]   out_conf;
  logic [4:0]   out_disp;
  logic         out_sol, out_eol, out_valid, out_ready;

  blk_mask_streamer dut (
    .clk        (clk),
    .reset      (reset),
    .xors_in    (xors_in),
    .conf_in    (conf_in),
    .disp_in    (disp_in),
    .xors_valid (xors_valid),
    .xors_ready (xors_ready),
    .out_count  (out_count),
    .out_conf   (out_conf),
    .out_disp   (out_disp),
    .out_sol    (out_sol),
    .out_eol    (out_eol),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0, n_tiles = 0;
  int ready_mode = 0;  // 0: always ready, 1: never, 2: 30 % random
  logic [255:0] row_mask [15];
  logic [7:0]   row_conf [15];
  logic [4:0]   row_disp [15];
  logic [17:0]  exp_q [$];
  logic [17:0]  got_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Tile = {count[2:0], conf[7:0], disp[4:0], sol, eol}
  function automatic logic [17:0] model_tile(input int ty, input int tx);
    int b, cnt;
    logic [7:0] bi;
    b = tx / 8;
    cnt = 0;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        bi = 8'((ty * 2 + dy) * 16 + (tx % 8) * 2 + dx);
        cnt += int'(row_mask[b][bi]);
      end
    return {3'(cnt), row_conf[b], row_disp[b], tx == 0, tx == 119};
  endfunction

  task automatic push_row_exp();
    for (int ty = 0; ty < 8; ty++)
      for (int tx = 0; tx < 120; tx++) exp_q.push_back(model_tile(ty, tx));
  endtask

  task automatic send_block(input int b, input int gap);
    int cyc;
    repeat (gap) @(negedge clk);
    xors_in    = row_mask[b];
    conf_in    = row_conf[b];
    disp_in    = row_disp[b];
    xors_valid = 1'b1;
    cyc = 0;
    while (!xors_ready && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 20000) check("accept_timeout", cyc, 0);
    @(negedge clk);
    xors_valid = 1'b0;
  endtask

  task automatic send_blocks(input int first, input int last, input int gap_max);
    for (int b = first; b <= last; b++)
      send_block(b, (gap_max > 0) ? int'($urandom_range(gap_max)) : 0);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check({"drain_", tag}, exp_q.size(), 0);
    repeat (8) @(negedge clk);
    check({"idle_", tag}, out_valid, 0);
  endtask

  task automatic fill_const(input logic [255:0] m, input logic [7:0] c, input logic [4:0] d);
    for (int b = 0; b < 15; b++) begin
      row_mask[b] = m;
      row_conf[b] = c;
      row_disp[b] = d;
    end
  endtask

  function automatic logic [255:0] checker_mask();
    logic [255:0] m;
    logic [7:0]   bi;
    m = '0;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        bi = 8'(r * 16 + c);
        m[bi] = 1'((r + c) & 1);
      end
    return m;
  endfunction

  function automatic logic [255:0] rand_mask();
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m = {m[223:0], 32'($urandom())};
    return m;
  endfunction

  // Consumer: decides out_ready each cycle and scores every handshaken tile.
  initial begin
    logic [17:0] tile;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(99) < 30);
      endcase
      if (!reset && out_valid && out_ready) begin
        tile = {out_count, out_conf, out_disp, out_sol, out_eol};
        got_q.push_back(tile);
        n_tiles++;
        if (exp_q.size() == 0) check("tile_extra", tile, 18'h0);
        else check($sformatf("tile%0d", n_tiles), tile, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] m;
    int sum, base, cyc;

    reset = 1'b1; xors_valid = 1'b0; xors_in = '0; conf_in = '0; disp_in = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_sol_eol", {out_sol, out_eol}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", xors_ready, 1);
    check("empty_no_valid", out_valid, 0);

    // 1: all-ones blocks
    fill_const('1, 8'd7, 5'd3);
    got_q.delete();
    push_row_exp();
    send_blocks(0, 14, 0);
    wait_drain("s1", 8000);
    check("s1_ntiles", got_q.size(), 960);
    check("s1_tile500", got_q[500], {3'd4, 8'd7, 5'd3, 1'b0, 1'b0});
    check("s1_sol0", got_q[0][1], 1);
    check("s1_eol119", got_q[119][0], 1);
    check("s1_sol120", got_q[120][1], 1);
    check("s1_eol959", got_q[959][0], 1);

    // 2: single set pixel in block 2 at r=3, c=5
    fill_const('0, 8'd0, 5'd0);
    m = '0;
    m[53] = 1'b1;
    row_mask[2] = m;
    got_q.delete();
    push_row_exp();
    send_blocks(0, 14, 0);
    wait_drain("s2", 8000);
    sum = 0;
    foreach (got_q[i]) sum += int'(got_q[i][17:15]);
    check("s2_total", sum, 1);
    check("s2_hit", got_q[138][17:15], 1);

    // 3: checkerboard, per-block conf/disp
    for (int k = 0; k < 15; k++) begin
      row_mask[k] = checker_mask();
      row_conf[k] = 8'(10 * k);
      row_disp[k] = 5'(k);
    end
    got_q.delete();
    push_row_exp();
    send_blocks(0, 14, 0);
    wait_drain("s3", 8000);
    check("s3_tile40", got_q[40], {3'd2, 8'd50, 5'd5, 1'b0, 1'b0});
    check("s3_tile119", got_q[119], {3'd2, 8'd140, 5'd14, 1'b0, 1'b1});

    // 4: backpressure, ring fills, 31st block held
    ready_mode = 1;
    fill_const('1, 8'h21, 5'd1);
    push_row_exp();
    send_blocks(0, 14, 0);
    fill_const(checker_mask(), 8'h22, 5'd2);
    push_row_exp();
    send_blocks(0, 14, 0);
    repeat (20) @(negedge clk);
    check("s4_full_ready", xors_ready, 0);
    check("s4_valid", out_valid, 1);
    check("s4_frozen_a", {out_count, out_conf, out_disp, out_sol, out_eol}, exp_q[0]);
    repeat (10) @(negedge clk);
    check("s4_frozen_b", {out_count, out_conf, out_disp, out_sol, out_eol}, exp_q[0]);
    for (int b = 0; b < 15; b++) begin
      row_mask[b] = rand_mask();
      row_conf[b] = 8'($urandom());
      row_disp[b] = 5'($urandom());
    end
    push_row_exp();
    xors_in = row_mask[0]; conf_in = row_conf[0]; disp_in = row_disp[0];
    xors_valid = 1'b1;
    repeat (50) @(negedge clk);
    check("s4_held", xors_ready, 0);
    base = n_tiles;
    ready_mode = 0;
    cyc = 0;
    while (!xors_ready && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    check("s4_accept_after_release", n_tiles - base, 960);
    @(negedge clk);
    xors_valid = 1'b0;
    send_blocks(1, 14, 0);
    wait_drain("s4", 20000);

    // 5: random backpressure and input gaps over 4 block-rows
    ready_mode = 2;
    got_q.delete();
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 15; b++) begin
        row_mask[b] = rand_mask();
        row_conf[b] = 8'($urandom());
        row_disp[b] = 5'($urandom());
      end
      push_row_exp();
      send_blocks(0, 14, 3);
    end
    wait_drain("s5", 40000);
    check("s5_ntiles", got_q.size(), 3840);

    // 6: reset during W_ROWS of block 7 and during R_HOLD
    ready_mode = 1;
    fill_const('1, 8'h55, 5'd9);
    push_row_exp();
    send_blocks(0, 14, 0);
    fill_const(checker_mask(), 8'h66, 5'd4);
    send_blocks(0, 7, 0);
    repeat (4) @(negedge clk);
    check("s6_hold_before_rst", out_valid, 1);
    #2 reset = 1'b1;
    #1;
    check("s6_rst_valid", out_valid, 0);
    check("s6_rst_count", out_count, 0);
    check("s6_rst_sol_eol", {out_sol, out_eol}, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("s6_ready_after_rst", xors_ready, 1);
    check("s6_no_valid", out_valid, 0);
    ready_mode = 0;
    got_q.delete();
    for (int k = 0; k < 15; k++) begin
      row_mask[k] = rand_mask();
      row_conf[k] = 8'(200 + k);
      row_disp[k] = 5'(31 - k);
    end
    push_row_exp();
    send_blocks(0, 14, 0);
    wait_drain("s6", 8000);
    check("s6_ntiles", got_q.size(), 960);
    check("s6_first_sol", got_q[0][1], 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
